// File: rtl/conv2d_ctrl.sv
// Frame sequencer for one conv2d_core: loads layer params, streams a W x H frame
// from src RAM, feeds psums from psum RAM and writes valid conv outputs to dst RAM.
module conv2d_ctrl #(
    parameter int C_WIDTH = 9,
    parameter int A_WIDTH = 16,
    parameter int KS      = 3,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [C_WIDTH-1:0]    cfg_width,
    input  logic [C_WIDTH-1:0]    cfg_height,
    input  logic [KS*KS*32-1:0]   cfg_weight,
    input  logic [A_WIDTH-1:0]    cfg_src_base,
    input  logic [A_WIDTH-1:0]    cfg_psum_base,
    input  logic [A_WIDTH-1:0]    cfg_dst_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  param_ena,
    output logic [KS*KS*32-1:0]   param_weight,
    output logic [C_WIDTH-1:0]    param_width_in,
    output logic                  pxl_ena_x,
    input  logic                  pxl_ena_y,
    input  logic                  pxl_ena_z,
    output logic                  src_rd_en,
    output logic [A_WIDTH-1:0]    src_rd_addr,
    output logic                  psum_rd_en,
    output logic [A_WIDTH-1:0]    psum_rd_addr,
    output logic                  dst_wr_en,
    output logic [A_WIDTH-1:0]    dst_wr_addr
);
    localparam int FW       = 2 * C_WIDTH;
    localparam int IW       = $clog2(TIMEOUT + 1);
    // The DONE state and the registered done add two cycles after the trip point,
    // so trip early to land done exactly TIMEOUT cycles after the last output.
    localparam int ABORT_AT = (TIMEOUT > 3) ? TIMEOUT - 3 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t               state;
    logic [C_WIDTH-1:0]   height_q;
    logic [A_WIDTH-1:0]   src_addr;
    logic [A_WIDTH-1:0]   psum_addr;
    logic [A_WIDTH-1:0]   dst_addr;
    logic [FW-1:0]        rd_cnt;
    logic [FW-1:0]        z_cnt;
    logic [C_WIDTH-1:0]   col_z;
    logic [IW-1:0]        idle_cnt;
    logic                 settle;
    logic [RD_LAT-1:0]    x_pipe;

    logic                 active;
    logic                 y_hit;
    logic                 z_hit;
    logic                 accept;
    logic [FW-1:0]        frame_px;
    logic [FW-1:0]        z_total;
    logic [FW-1:0]        z_next;

    assign active   = (state == S_STREAM) || (state == S_DRAIN);
    assign y_hit    = pxl_ena_y & active;
    assign z_hit    = pxl_ena_z & active;
    assign accept   = (state == S_IDLE) & start;
    assign frame_px = FW'(param_width_in) * FW'(height_q);
    assign z_total  = FW'(height_q - C_WIDTH'(KS - 1)) * FW'(param_width_in);
    assign z_next   = z_cnt + FW'(z_hit);

    assign busy         = (state != S_IDLE);
    assign pxl_ena_x    = x_pipe[RD_LAT-1];
    assign src_rd_addr  = src_addr;
    assign psum_rd_en   = y_hit;
    assign psum_rd_addr = psum_addr;
    assign dst_wr_en    = z_hit & (col_z >= C_WIDTH'(KS - 1));
    assign dst_wr_addr  = dst_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            param_ena      <= 1'b0;
            param_weight   <= '0;
            param_width_in <= '0;
            height_q       <= '0;
            src_rd_en      <= 1'b0;
            src_addr       <= '0;
            rd_cnt         <= '0;
            settle         <= 1'b0;
            idle_cnt       <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            param_ena <= 1'b0;
            done      <= 1'b0;
            if (active) begin
                if (z_hit)
                    idle_cnt <= '0;
                else if (idle_cnt < IW'(ABORT_AT))
                    idle_cnt <= idle_cnt + 1'b1;
            end
            case (state)
                S_IDLE: if (start) begin
                    param_weight   <= cfg_weight;
                    param_width_in <= cfg_width;
                    height_q       <= cfg_height;
                    src_addr       <= cfg_src_base;
                    err            <= 1'b0;
                    if (cfg_width < C_WIDTH'(KS) || cfg_height < C_WIDTH'(KS)) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        param_ena <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    settle <= 1'b0;
                    state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    settle <= 1'b1;
                    if (settle) begin
                        src_rd_en <= 1'b1;
                        rd_cnt    <= '0;
                        idle_cnt  <= '0;
                        state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    src_addr <= src_addr + 1'b1;
                    rd_cnt   <= rd_cnt + 1'b1;
                    if (rd_cnt == frame_px - 1'b1) begin
                        src_rd_en <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (z_next >= z_total) begin
                        state <= S_DONE;
                    end else if (!z_hit && idle_cnt >= IW'(ABORT_AT)) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-side and write-side counters follow the core's strobes, not the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_addr <= '0;
            dst_addr  <= '0;
            z_cnt     <= '0;
            col_z     <= '0;
            x_pipe    <= '0;
        end else begin
            x_pipe[0] <= src_rd_en;
            for (int i = 1; i < RD_LAT; i++)
                x_pipe[i] <= x_pipe[i-1];
            if (accept) begin
                psum_addr <= cfg_psum_base;
                dst_addr  <= cfg_dst_base;
                z_cnt     <= '0;
                col_z     <= '0;
            end else begin
                if (y_hit)
                    psum_addr <= psum_addr + 1'b1;
                if (z_hit) begin
                    z_cnt <= z_next;
                    col_z <= (col_z == param_width_in - 1'b1) ? '0 : col_z + 1'b1;
                end
                if (dst_wr_en)
                    dst_addr <= dst_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv2d_ctrl.sv
// Directed bench for conv2d_ctrl: a simple core model drives y/z, a scoreboard
// checks every RAM access, param load and done pulse against expected queues.
module tb_conv2d_ctrl;
    localparam int CW = 9, AW = 16, KS = 3, RD_LAT = 1, TO = 255;
    localparam int PW = KS * KS * 32;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [CW-1:0] cfg_width = '0, cfg_height = '0;
    logic [PW-1:0] cfg_weight = '0;
    logic [AW-1:0] cfg_src_base = '0, cfg_psum_base = '0, cfg_dst_base = '0;
    logic busy, done, err, param_ena, pxl_ena_x, src_rd_en, psum_rd_en, dst_wr_en;
    logic [PW-1:0] param_weight;
    logic [CW-1:0] param_width_in;
    logic [AW-1:0] src_rd_addr, psum_rd_addr, dst_wr_addr;
    logic pxl_ena_y = 1'b0, pxl_ena_z = 1'b0;

    conv2d_ctrl #(.C_WIDTH(CW), .A_WIDTH(AW), .KS(KS), .RD_LAT(RD_LAT), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_weight(cfg_weight),
        .cfg_src_base(cfg_src_base), .cfg_psum_base(cfg_psum_base), .cfg_dst_base(cfg_dst_base),
        .busy(busy), .done(done), .err(err), .param_ena(param_ena),
        .param_weight(param_weight), .param_width_in(param_width_in),
        .pxl_ena_x(pxl_ena_x), .pxl_ena_y(pxl_ena_y), .pxl_ena_z(pxl_ena_z),
        .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr),
        .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr),
        .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct { int cyc; int val; } ev_t;
    typedef struct { int lo; int hi; logic err; } dn_t;
    ev_t src_q[$], psum_q[$], dst_q[$], par_q[$];
    dn_t done_q[$];
    ev_t ev_m;
    dn_t dn_m;
    logic [PW-1:0] exp_weight = '0;

    // Core model: y with each x from row KS-1 on, z one cycle after y, optional z cap.
    int xcnt = 0, zsent = 0, zlim = 0, fw = 1;
    logic zpend = 1'b0, force_yz = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            xcnt = 0; zsent = 0; zpend = 1'b0;
            pxl_ena_y = 1'b0; pxl_ena_z = 1'b0;
        end else if (force_yz) begin
            pxl_ena_y = 1'b1; pxl_ena_z = 1'b1; zpend = 1'b0;
        end else begin
            pxl_ena_z = zpend && (zsent < zlim);
            if (pxl_ena_z) zsent++;
            pxl_ena_y = pxl_ena_x && (xcnt >= (KS - 1) * fw);
            zpend = pxl_ena_y;
            if (pxl_ena_x) xcnt++;
        end
    end

    // Scoreboard: every strobe must match the head of its queue.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (param_ena) begin
                if (par_q.size() == 0) chk("param_unexpected", param_ena, 1'b0);
                else begin
                    ev_m = par_q.pop_front();
                    chk("param_cyc", cyc, ev_m.cyc);
                    chk("param_width", param_width_in, ev_m.val);
                    chk("param_weight", param_weight, exp_weight);
                end
            end
            if (src_rd_en) begin
                if (src_q.size() == 0) chk("src_unexpected", src_rd_en, 1'b0);
                else begin
                    ev_m = src_q.pop_front();
                    chk("src_cyc", cyc, ev_m.cyc);
                    chk("src_addr", src_rd_addr, ev_m.val);
                end
            end
            if (psum_rd_en) begin
                if (psum_q.size() == 0) chk("psum_unexpected", psum_rd_en, 1'b0);
                else begin
                    ev_m = psum_q.pop_front();
                    chk("psum_cyc", cyc, ev_m.cyc);
                    chk("psum_addr", psum_rd_addr, ev_m.val);
                end
            end
            if (dst_wr_en) begin
                if (dst_q.size() == 0) chk("dst_unexpected", dst_wr_en, 1'b0);
                else begin
                    ev_m = dst_q.pop_front();
                    chk("dst_cyc", cyc, ev_m.cyc);
                    chk("dst_addr", dst_wr_addr, ev_m.val);
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", done, 1'b0);
                else begin
                    dn_m = done_q.pop_front();
                    chk("done_cyc_window", (cyc >= dn_m.lo) && (cyc <= dn_m.hi), 1'b1);
                    chk("done_err", err, dn_m.err);
                end
            end
        end
    end

    // Drives a 1-cycle start at cycle s and pushes the expected accesses of a good frame.
    task automatic frame(input int w, input int h, input int sb, input int pb, input int db,
                         input int zl, input bit good, output int s);
        int k;
        s = cyc;
        cfg_width = CW'(w); cfg_height = CW'(h);
        cfg_weight = {9{$urandom()}};
        cfg_src_base = AW'(sb); cfg_psum_base = AW'(pb); cfg_dst_base = AW'(db);
        xcnt = 0; zsent = 0; zlim = zl; fw = w;
        if (good) begin
            exp_weight = cfg_weight;
            par_q.push_back('{s + 1, w});
            for (int i = 0; i < w * h; i++) src_q.push_back('{s + 4 + i, sb + i});
            for (int p = (KS - 1) * w; p < w * h; p++) psum_q.push_back('{s + 5 + p, pb + p - (KS - 1) * w});
            k = 0;
            for (int p = (KS - 1) * w; p < w * h; p++)
                if (p % w >= KS - 1 && p - (KS - 1) * w < zl) begin
                    dst_q.push_back('{s + 6 + p, db + k});
                    k++;
                end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        bit got = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk); #3;
            if (done) begin got = 1; break; end
        end
        if (!got) chk("done_wait", done, 1'b1);
        @(posedge clk); #1;
    endtask

    int s;
    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_param_ena", param_ena, 1'b0);
        chk("rst_src_rd_en", src_rd_en, 1'b0);
        chk("rst_src_addr", src_rd_addr, '0);
        chk("rst_psum_addr", psum_rd_addr, '0);
        chk("rst_dst_addr", dst_wr_addr, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // y/z while idle must not touch RAM
        force_yz = 1'b1;
        @(negedge clk); #3;
        chk("idle_psum_rd_en", psum_rd_en, 1'b0);
        chk("idle_dst_wr_en", dst_wr_en, 1'b0);
        force_yz = 1'b0;
        @(posedge clk); #1;

        // nominal 5x4 frame
        frame(5, 4, 0, 100, 200, 1000, 1'b1, s);
        done_q.push_back('{s + 26, s + 27, 1'b0});
        chk("frame_a_busy", busy, 1'b1);
        wait_done(60);
        chk("frame_a_idle", busy, 1'b0);
        chk("frame_a_src_q", src_q.size(), 0);
        chk("frame_a_psum_q", psum_q.size(), 0);
        chk("frame_a_dst_q", dst_q.size(), 0);

        // W<KS: immediate error, plus a good start in the DONE cycle that must be dropped
        frame(2, 4, 0, 100, 200, 1000, 1'b0, s);
        done_q.push_back('{s + 2, s + 2, 1'b1});
        cfg_width = 5; cfg_height = 4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("badcfg_err", err, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("badcfg_no_frame", busy, 1'b0);
        chk("badcfg_err_sticky", err, 1'b1);

        // 6x3 frame with start held through STREAM, DRAIN and DONE
        frame(6, 3, 500, 600, 700, 1000, 1'b1, s);
        done_q.push_back('{s + 24, s + 25, 1'b0});
        chk("frame_b_err_clear", err, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        cfg_src_base = 9000; cfg_psum_base = 9100; cfg_dst_base = 9200;
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #3;
            if (done) break;
        end
        start = 1'b0;
        chk("frame_b_done_seen", done, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("frame_b_no_restart", busy, 1'b0);

        // core stalls after 3 outputs: timeout abort
        frame(5, 4, 40, 140, 240, 3, 1'b1, s);
        done_q.push_back('{s + 18 + TO, s + 18 + TO, 1'b1});
        wait_done(TO + 60);
        chk("timeout_err", err, 1'b1);
        chk("timeout_idle", busy, 1'b0);

        // async reset in the middle of STREAM
        frame(5, 4, 1000, 1100, 1200, 1000, 1'b1, s);
        repeat (9) @(posedge clk);
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_src_rd_en", src_rd_en, 1'b0);
        chk("midrst_pxl_ena_x", pxl_ena_x, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_src_addr", src_rd_addr, '0);
        chk("midrst_psum_addr", psum_rd_addr, '0);
        chk("midrst_dst_addr", dst_wr_addr, '0);
        chk("midrst_param_weight", param_weight, '0);
        chk("midrst_width", param_width_in, '0);
        src_q.delete(); psum_q.delete(); dst_q.delete(); par_q.delete(); done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame(5, 4, 300, 400, 500, 1000, 1'b1, s);
        done_q.push_back('{s + 26, s + 27, 1'b0});
        wait_done(60);

        chk("end_src_q", src_q.size(), 0);
        chk("end_psum_q", psum_q.size(), 0);
        chk("end_dst_q", dst_q.size(), 0);
        chk("end_par_q", par_q.size(), 0);
        chk("end_done_q", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
